// File: rtl/mux8_ser_seq.sv
// Byte-to-serial sequencer driving the select and enable of a downstream 8:1 mux.
// Loads a byte over valid/ready, then steps s from 0 to 7 (MSB first), DIV clocks per bit.
module mux8_ser_seq #(
    parameter int DIV  = 1,
    parameter int DIVW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       hold,
    output logic [7:0] a,
    output logic [2:0] s,
    output logic       en,
    output logic       bit_stb,
    output logic       last,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

    state_t          state_reg, state_next;
    logic [7:0]      a_reg, a_next;
    logic [2:0]      s_reg, s_next;
    logic            en_reg, en_next;
    logic [DIVW-1:0] div_cnt_reg, div_cnt_next;

    logic bit_final;
    logic accept;

    // The bit-final cycle is the only point where the sequence advances s or ends.
    assign bit_final = (state_reg == SHIFT) && !hold && (div_cnt_reg == DIV_LAST);
    assign din_ready = (state_reg == IDLE) || (bit_final && (s_reg == 3'd7));
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= 8'h00;
            s_reg       <= 3'd0;
            en_reg      <= 1'b0;
            div_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            s_reg       <= s_next;
            en_reg      <= en_next;
            div_cnt_reg <= div_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        s_next       = s_reg;
        en_next      = en_reg;
        div_cnt_next = div_cnt_reg;

        if (accept) begin
            // Covers both a fresh start from IDLE and a gapless reload at s==7.
            state_next   = SHIFT;
            a_next       = din;
            s_next       = 3'd0;
            en_next      = 1'b1;
            div_cnt_next = '0;
        end else if ((state_reg == SHIFT) && !hold) begin
            if (bit_final) begin
                div_cnt_next = '0;
                if (s_reg != 3'd7) begin
                    s_next = s_reg + 3'd1;
                end else begin
                    state_next = IDLE;
                    en_next    = 1'b0;
                    s_next     = 3'd0;
                end
            end else begin
                div_cnt_next = div_cnt_reg + DIVW'(1);
            end
        end
    end

    assign a       = a_reg;
    assign s       = s_reg;
    assign en      = en_reg;
    assign busy    = en_reg;
    assign bit_stb = bit_final;
    assign last    = en_reg && (s_reg == 3'd7);

endmodule

// File: tb/tb_mux8_ser_seq.sv
// Directed bench for mux8_ser_seq with three instances (DIV=1, 2, 4) sharing clk and rst.
module tb_mux8_ser_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din    [3];
    logic       dv     [3];
    logic       hd     [3];
    logic       rdy_o  [3];
    logic [7:0] a_o    [3];
    logic [2:0] s_o    [3];
    logic       en_o   [3];
    logic       stb_o  [3];
    logic       last_o [3];
    logic       busy_o [3];

    mux8_ser_seq #(.DIV(1), .DIVW(8)) u_div1 (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy_o[0]),
        .hold(hd[0]), .a(a_o[0]), .s(s_o[0]), .en(en_o[0]), .bit_stb(stb_o[0]),
        .last(last_o[0]), .busy(busy_o[0])
    );
    mux8_ser_seq #(.DIV(2), .DIVW(8)) u_div2 (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy_o[1]),
        .hold(hd[1]), .a(a_o[1]), .s(s_o[1]), .en(en_o[1]), .bit_stb(stb_o[1]),
        .last(last_o[1]), .busy(busy_o[1])
    );
    mux8_ser_seq #(.DIV(4), .DIVW(8)) u_div4 (
        .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy_o[2]),
        .hold(hd[2]), .a(a_o[2]), .s(s_o[2]), .en(en_o[2]), .bit_stb(stb_o[2]),
        .last(last_o[2]), .busy(busy_o[2])
    );

    typedef struct {
        logic [7:0] din;
        logic       dv;
        logic       hold;
        logic [7:0] ea;
        int         es;
        logic       een;
        logic       estb;
        logic       elast;
        logic       erdy;
        logic       ey;
    } vec_t;

    vec_t tbl [10];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output of the downstream mux: s=0 selects a[7]; gated off when en is low.
    function automatic logic mux_y(input int k);
        logic [2:0] idx;
        idx = 3'd7 - s_o[k];
        return en_o[k] ? a_o[k][idx] : 1'b0;
    endfunction

    task automatic chk_all(input int k, input string tag, input int ea, input int es,
                           input int een, input int estb, input int elast, input int erdy);
        chk($sformatf("%s.a", tag), int'(a_o[k]), ea);
        chk($sformatf("%s.s", tag), int'(s_o[k]), es);
        chk($sformatf("%s.en", tag), int'(en_o[k]), een);
        chk($sformatf("%s.busy", tag), int'(busy_o[k]), een);
        chk($sformatf("%s.bit_stb", tag), int'(stb_o[k]), estb);
        chk($sformatf("%s.last", tag), int'(last_o[k]), elast);
        chk($sformatf("%s.din_ready", tag), int'(rdy_o[k]), erdy);
    endtask

    initial begin
        logic [7:0] b;
        int es;
        int en_cycles;
        logic hold_now;
        logic stb_exp;

        for (int k = 0; k < 3; k++) begin
            din[k] = 8'h00;
            dv[k]  = 1'b0;
            hd[k]  = 1'b0;
        end

        // Single byte B4 at DIV=1: idle vector, eight bit cycles, back to idle.
        tbl[0] = '{din: 8'hB4, dv: 1'b1, hold: 1'b0, ea: 8'h00, es: 0, een: 1'b0,
                   estb: 1'b0, elast: 1'b0, erdy: 1'b1, ey: 1'b0};
        b = 8'hB4;
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{din: 8'h00, dv: 1'b0, hold: 1'b0, ea: 8'hB4, es: i - 1, een: 1'b1,
                       estb: 1'b1, elast: (i == 8), erdy: (i == 8), ey: b[8 - i]};
        end
        tbl[9] = '{din: 8'h00, dv: 1'b0, hold: 1'b0, ea: 8'hB4, es: 0, een: 1'b0,
                   estb: 1'b0, elast: 1'b0, erdy: 1'b1, ey: 1'b0};

        // Test 1: reset with clock running, then async reset mid-byte.
        rst = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) chk_all(k, $sformatf("rst%0d", k), 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        tick();

        din[0] = 8'hC3;
        dv[0]  = 1'b1;
        tick();
        dv[0] = 1'b0;
        repeat (4) tick();
        chk("midrst.pre_s", int'(s_o[0]), 4);
        rst = 1'b1;
        #1;
        chk_all(0, "midrst", 0, 0, 0, 0, 0, 1);
        tick();
        rst = 1'b0;
        tick();

        // Test 2: table-driven single byte.
        en_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            din[0] = tbl[i].din;
            dv[0]  = tbl[i].dv;
            hd[0]  = tbl[i].hold;
            #1;
            chk_all(0, $sformatf("single[%0d]", i), int'(tbl[i].ea), tbl[i].es, int'(tbl[i].een),
                    int'(tbl[i].estb), int'(tbl[i].elast), int'(tbl[i].erdy));
            chk($sformatf("single[%0d].y", i), int'(mux_y(0)), int'(tbl[i].ey));
            if (en_o[0]) en_cycles++;
            tick();
        end
        chk("single.en_cycles", en_cycles, 8);

        // Test 3: back-to-back A5 then 3C, valid held high.
        din[0] = 8'hA5;
        dv[0]  = 1'b1;
        #1;
        chk("b2b.ready0", int'(rdy_o[0]), 1);
        tick();
        din[0] = 8'h3C;
        for (int c = 1; c <= 16; c++) begin
            if (c == 9) dv[0] = 1'b0;
            #1;
            es = (c - 1) % 8;
            b  = (c <= 8) ? 8'hA5 : 8'h3C;
            chk_all(0, $sformatf("b2b[%0d]", c), int'(b), es, 1, 1, int'(es == 7), int'(es == 7));
            chk($sformatf("b2b[%0d].y", c), int'(mux_y(0)), int'(b[7 - es]));
            tick();
        end
        chk("b2b.end_en", int'(en_o[0]), 0);
        chk("b2b.end_ready", int'(rdy_o[0]), 1);

        // Test 4: DIV=4 prescale with byte 81.
        din[2] = 8'h81;
        dv[2]  = 1'b1;
        #1;
        tick();
        dv[2] = 1'b0;
        for (int c = 0; c < 32; c++) begin
            #1;
            es = c / 4;
            chk_all(2, $sformatf("div4[%0d]", c), 8'h81, es, 1, int'(c % 4 == 3),
                    int'(es == 7), int'(es == 7 && c % 4 == 3));
            chk($sformatf("div4[%0d].y", c), int'(mux_y(2)), int'(es == 0 || es == 7));
            tick();
        end
        chk("div4.end_en", int'(en_o[2]), 0);

        // Test 5: DIV=2, hold for 3 cycles at the start of s=2; 19 en-high cycles in total.
        din[1] = 8'hF0;
        dv[1]  = 1'b1;
        #1;
        tick();
        dv[1] = 1'b0;
        for (int c = 0; c < 19; c++) begin
            hold_now = (c >= 4 && c < 7);
            hd[1]    = hold_now;
            #1;
            if (c < 4) es = c / 2;
            else if (c < 7) es = 2;
            else es = (c - 3) / 2;
            stb_exp = !hold_now && ((c < 4) ? (c % 2 == 1) : ((c - 3) % 2 == 1));
            chk_all(1, $sformatf("hold[%0d]", c), 8'hF0, es, 1, int'(stb_exp),
                    int'(es == 7), int'(stb_exp && es == 7));
            chk($sformatf("hold[%0d].y", c), int'(mux_y(1)), int'(es < 4));
            tick();
        end
        hd[1] = 1'b0;
        #1;
        chk("hold.end_en", int'(en_o[1]), 0);

        // Test 6: hold ignored in IDLE; FF offered at s=3 is only taken at the s=7 bit-final cycle.
        hd[0]  = 1'b1;
        din[0] = 8'h11;
        dv[0]  = 1'b1;
        #1;
        chk("ign.idle_hold_ready", int'(rdy_o[0]), 1);
        tick();
        hd[0] = 1'b0;
        dv[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin
                din[0] = 8'hFF;
                dv[0]  = 1'b1;
            end
            #1;
            chk($sformatf("ign[%0d].a", c), int'(a_o[0]), 8'h11);
            chk($sformatf("ign[%0d].s", c), int'(s_o[0]), c);
            chk($sformatf("ign[%0d].din_ready", c), int'(rdy_o[0]), int'(c == 7));
            tick();
        end
        dv[0] = 1'b0;
        #1;
        chk("ign.new_a", int'(a_o[0]), 8'hFF);
        chk("ign.new_s", int'(s_o[0]), 0);
        chk("ign.new_en", int'(en_o[0]), 1);
        repeat (8) tick();
        chk("ign.end_en", int'(en_o[0]), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mux8_ser_seq.md
Name: mux8_ser_seq

Overview:
- Sequencer that sits directly upstream of the 8:1 select mux.
- Accepts a parallel byte over a valid/ready handshake and holds it on the mux data bus `a`.
- Steps the mux select `s` from 0 to 7 while driving the mux enable `en`. With the mux mapping s=0→a[7], the serial output is MSB first.
- Provides bit strobes and last-bit flags so the consumer knows when the mux output `y` is valid to sample.

Parameters:
- DIV, 1, clocks per serial bit; legal range 1..255.
- DIVW, 8, width of the internal bit-period counter; must satisfy 2^DIVW > DIV-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  8  parallel byte to serialize.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept din this cycle (combinational).
- hold  input  1  freeze the sequence in place.
- a  output  8  registered byte, to the mux data input.
- s  output  3  registered select, to the mux select.
- en  output  1  registered mux enable; high only while shifting.
- bit_stb  output  1  one-cycle strobe on the final cycle of each bit period.
- last  output  1  high while s==7 and en==1.
- busy  output  1  high in the SHIFT state.

Behaviour:
- Reset, asynchronous, effective immediately even mid-byte:
  - state=IDLE, a=8'h00, s=3'd0, en=0, div_cnt=0, bit_stb=0.
  - busy=0, last=0, din_ready=1.
- States: IDLE and SHIFT.
- din_ready (combinational):
  - 1 in IDLE.
  - In SHIFT, 1 only on the final cycle of bit 7, i.e. s==7 && div_cnt==DIV-1 && !hold.
  - 0 otherwise.
- Accept occurs on a rising edge where din_valid && din_ready. At that edge:
  - a<=din, s<=0, div_cnt<=0, en<=1, state<=SHIFT.
  - The first bit, din[7] via the mux, is presented in the cycle after the accept edge.
- SHIFT, per cycle with hold=0:
  - If div_cnt<DIV-1: div_cnt increments.
  - Otherwise (div_cnt==DIV-1, the bit-final cycle): bit_stb=1 (combinational), div_cnt<=0, and:
    - s<7: s<=s+1.
    - s==7 with accept: reload a and restart at s=0. Back-to-back bytes have no gap cycle; en stays 1.
    - s==7 without accept: state<=IDLE, en<=0, s<=0; a retains its value.
- hold=1 in SHIFT:
  - div_cnt, s, a, en frozen.
  - bit_stb=0 and din_ready=0.
  - A bit period is stretched by the number of held cycles.
- hold in IDLE has no effect; accept is still permitted.
- din and din_valid are ignored whenever din_ready=0.
- DIV=1: div_cnt stays 0, bit_stb is high on every unheld SHIFT cycle, one bit per clock.
- s arithmetic is 3-bit; it never wraps through 7→0 except via reload or IDLE return.
- Unheld byte duration is exactly 8*DIV cycles with en=1. Exactly 8 bit_stb pulses are produced per byte.
- busy == en at all times; last is combinational from s and en.

Test Plan:
1. Reset, DIV=1:
   - Pulse rst with clk running. Expect a=00, s=0, en=0, busy=0, din_ready=1.
   - Assert rst mid-byte at s=4. Expect all outputs to return to reset values before the next edge.
2. Single byte, DIV=1:
   - din=8'hB4, valid for 1 cycle.
   - en high for exactly 8 cycles, s=0..7, 8 bit_stb pulses, last high only at s=7.
   - Mux y sequence is 1,0,1,1,0,1,0,0. Then IDLE, en=0.
3. Back-to-back, DIV=1:
   - din_valid held high with 8'hA5 then 8'h3C.
   - din_ready pulses only at s=7. en stays 1 for 16 consecutive cycles.
   - y = 10100101 followed by 00111100, with no gap.
4. Prescale, DIV=4:
   - din=8'h81. Each s value lasts 4 cycles and bit_stb fires on the 4th cycle of each.
   - Total en-high time 32 cycles; y=1 during s=0 and s=7 only.
5. Hold, DIV=2:
   - din=8'hF0. Assert hold for 3 cycles while s=2.
   - s and div_cnt are frozen, with no bit_stb and din_ready=0. Total en-high time 19 cycles; bit order is unchanged.
6. Ignored input:
   - While SHIFT at s=3, drive din=8'hFF with din_valid=1.
   - a is unchanged until the s=7 bit-final cycle. The byte is accepted there and the new sequence starts with s=0 and a=8'hFF.
